// File: rtl/systolic_chain_sequencer_if.sv
// Host byte stream, result byte stream and PE-chain control bundle for the chain sequencer.
// master is the sequencer side; slave is the host/consumer/chain side.
interface systolic_chain_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              pe_w_load;
  logic [DATA_W-1:0] pe_w_data;
  logic              pe_acc_clr;
  logic              pe_x_valid;
  logic [DATA_W-1:0] pe_x_data;
  logic              pe_out_shift;
  logic [ACC_W-1:0]  pe_res;

  modport master (
    input  in_data, in_valid, out_ready, pe_res,
    output in_ready, out_data, out_valid,
    output pe_w_load, pe_w_data, pe_acc_clr, pe_x_valid, pe_x_data, pe_out_shift
  );

  modport slave (
    output in_data, in_valid, out_ready, pe_res,
    input  in_ready, out_data, out_valid,
    input  pe_w_load, pe_w_data, pe_acc_clr, pe_x_valid, pe_x_data, pe_out_shift
  );
endinterface

// File: rtl/systolic_chain_sequencer.sv
// Runs one job through a weight-stationary PE chain: load weights, clear, stream activations,
// drain, then unload each accumulator tail-first as little-endian bytes.
module systolic_chain_sequencer #(
  parameter int unsigned N_PE   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] vec_len_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  systolic_chain_sequencer_if.master bus
);

  localparam int unsigned NB = ACC_W / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned RW = $clog2(N_PE);
  localparam int unsigned WW = $clog2(N_PE) + 1;
  localparam int unsigned DW = $clog2(N_PE + 2);

  typedef enum logic [2:0] {
    StIdle, StLoadW, StAccClr, StStream, StDrain, StRead, StShift, StDone
  } state_e;

  state_e            state_q;
  logic [7:0]        vec_len_q;
  logic [WW-1:0]     w_cnt_q;
  logic [7:0]        x_cnt_q;
  logic [DW-1:0]     drain_cnt_q;
  logic [BW-1:0]     byte_cnt_q;
  logic [RW-1:0]     res_cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              pe_w_load_q;
  logic [DATA_W-1:0] pe_w_data_q;
  logic              pe_acc_clr_q;
  logic              pe_x_valid_q;
  logic [DATA_W-1:0] pe_x_data_q;
  logic              pe_out_shift_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        out_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      vec_len_q      <= '0;
      w_cnt_q        <= '0;
      x_cnt_q        <= '0;
      drain_cnt_q    <= '0;
      byte_cnt_q     <= '0;
      res_cnt_q      <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      pe_w_load_q    <= 1'b0;
      pe_w_data_q    <= '0;
      pe_acc_clr_q   <= 1'b0;
      pe_x_valid_q   <= 1'b0;
      pe_x_data_q    <= '0;
      pe_out_shift_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else if (abort_i) begin
      // Abort wins over start; any partially sent result is dropped.
      state_q        <= StIdle;
      vec_len_q      <= '0;
      w_cnt_q        <= '0;
      x_cnt_q        <= '0;
      drain_cnt_q    <= '0;
      byte_cnt_q     <= '0;
      res_cnt_q      <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      pe_w_load_q    <= 1'b0;
      pe_w_data_q    <= '0;
      pe_acc_clr_q   <= 1'b0;
      pe_x_valid_q   <= 1'b0;
      pe_x_data_q    <= '0;
      pe_out_shift_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      pe_w_load_q    <= 1'b0;
      pe_w_data_q    <= '0;
      pe_acc_clr_q   <= 1'b0;
      pe_x_valid_q   <= 1'b0;
      pe_x_data_q    <= '0;
      pe_out_shift_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (vec_len_i != 8'd0) begin
              vec_len_q  <= vec_len_i;
              w_cnt_q    <= '0;
              x_cnt_q    <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= StLoadW;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        StLoadW: begin
          if (bus.in_valid && in_ready_q) begin
            pe_w_load_q <= 1'b1;
            pe_w_data_q <= bus.in_data;
            w_cnt_q     <= w_cnt_q + WW'(1);
            if (w_cnt_q == WW'(N_PE - 1)) begin
              in_ready_q <= 1'b0;
              state_q    <= StAccClr;
            end
          end
        end

        StAccClr: begin
          pe_acc_clr_q <= 1'b1;
          in_ready_q   <= 1'b1;
          state_q      <= StStream;
        end

        StStream: begin
          if (bus.in_valid && in_ready_q) begin
            pe_x_valid_q <= 1'b1;
            pe_x_data_q  <= bus.in_data;
            x_cnt_q      <= x_cnt_q + 8'd1;
            if (x_cnt_q == vec_len_q - 8'd1) begin
              in_ready_q  <= 1'b0;
              drain_cnt_q <= '0;
              state_q     <= StDrain;
            end
          end
        end

        // N_PE+1 cycles: last activation reaches the tail PE plus one register stage.
        StDrain: begin
          drain_cnt_q <= drain_cnt_q + DW'(1);
          if (drain_cnt_q == DW'(N_PE)) begin
            out_valid_q <= 1'b1;
            byte_cnt_q  <= '0;
            res_cnt_q   <= '0;
            state_q     <= StRead;
          end
        end

        StRead: begin
          if (bus.out_ready) begin
            if (byte_cnt_q == BW'(NB - 1)) begin
              byte_cnt_q  <= '0;
              out_valid_q <= 1'b0;
              if (res_cnt_q == RW'(N_PE - 1)) begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                res_cnt_q      <= res_cnt_q + RW'(1);
                pe_out_shift_q <= 1'b1;
                state_q        <= StShift;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + BW'(1);
            end
          end
        end

        // Chain shifts at the end of this cycle; next result is visible on pe_res after it.
        StShift: begin
          out_valid_q <= 1'b1;
          state_q     <= StRead;
        end

        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Result byte is muxed straight from pe_res, which the chain holds steady while unloading.
  always_comb begin
    out_byte = '0;
    for (int b = 0; b < NB; b++) begin
      if (out_valid_q && byte_cnt_q == BW'(b)) begin
        out_byte = bus.pe_res[b*8 +: 8];
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_byte;
  assign bus.pe_w_load    = pe_w_load_q;
  assign bus.pe_w_data    = pe_w_data_q;
  assign bus.pe_acc_clr   = pe_acc_clr_q;
  assign bus.pe_x_valid   = pe_x_valid_q;
  assign bus.pe_x_data    = pe_x_data_q;
  assign bus.pe_out_shift = pe_out_shift_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_systolic_chain_sequencer.sv
// Directed bench for systolic_chain_sequencer with a behavioural 4-PE weight-stationary chain.
module tb_systolic_chain_sequencer;
  localparam int unsigned NPe = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] vec_len = 8'd0;
  logic       abort   = 1'b0;
  logic       busy;
  logic       done;
  logic       err;

  systolic_chain_sequencer_if #(.DATA_W(8), .ACC_W(16)) bus_if ();

  systolic_chain_sequencer #(.N_PE(NPe), .DATA_W(8), .ACC_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .vec_len_i(vec_len),
    .abort_i  (abort),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  // Chain model: first loaded weight ends in PE0, activations ripple one PE per cycle.
  logic [7:0]  w_m   [NPe];
  logic [15:0] acc_m [NPe];
  logic        xv_m  [NPe-1];
  logic [7:0]  xd_m  [NPe-1];

  assign bus_if.pe_res = acc_m[NPe-1];

  always @(posedge clk) begin
    if (bus_if.pe_w_load) begin
      for (int i = 0; i < NPe - 1; i++) w_m[i] <= w_m[i+1];
      w_m[NPe-1] <= bus_if.pe_w_data;
    end
    xv_m[0] <= bus_if.pe_x_valid;
    xd_m[0] <= bus_if.pe_x_data;
    for (int i = 1; i < NPe - 1; i++) begin
      xv_m[i] <= xv_m[i-1];
      xd_m[i] <= xd_m[i-1];
    end
    if (bus_if.pe_acc_clr) begin
      for (int i = 0; i < NPe; i++) acc_m[i] <= 16'd0;
    end else if (bus_if.pe_out_shift) begin
      acc_m[0] <= 16'd0;
      for (int i = 1; i < NPe; i++) acc_m[i] <= acc_m[i-1];
    end else begin
      if (bus_if.pe_x_valid) acc_m[0] <= acc_m[0] + 16'(w_m[0]) * 16'(bus_if.pe_x_data);
      for (int i = 1; i < NPe; i++) begin
        if (xv_m[i-1]) acc_m[i] <= acc_m[i] + 16'(w_m[i]) * 16'(xd_m[i-1]);
      end
    end
  end

  // Negedge monitor: event counts and captured result bytes for the current job.
  logic       mon_clr = 1'b1;
  int         exp_x   = 0;
  int         n_wl, n_clr, n_xv, n_sh, n_done, n_err, n_busy, n_bub, n_stall_bad;
  logic       busy_at_done, busy_after_done, prev_done, prev_stall;
  logic [7:0] prev_data;
  logic [7:0] rxq [$];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_wl <= 0; n_clr <= 0; n_xv <= 0; n_sh <= 0; n_done <= 0; n_err <= 0;
      n_busy <= 0; n_bub <= 0; n_stall_bad <= 0;
      busy_at_done <= 1'b0; busy_after_done <= 1'b1; prev_done <= 1'b0; prev_stall <= 1'b0;
      prev_data <= 8'd0;
      rxq.delete();
    end else begin
      if (bus_if.pe_w_load) n_wl <= n_wl + 1;
      if (bus_if.pe_acc_clr) n_clr <= n_clr + 1;
      if (bus_if.pe_x_valid) n_xv <= n_xv + 1;
      else if (n_xv > 0 && n_xv < exp_x) n_bub <= n_bub + 1;
      if (bus_if.pe_out_shift) n_sh <= n_sh + 1;
      if (done) n_done <= n_done + 1;
      if (err) n_err <= n_err + 1;
      if (busy) n_busy <= n_busy + 1;
      if (prev_stall && (!bus_if.out_valid || bus_if.out_data != prev_data))
        n_stall_bad <= n_stall_bad + 1;
      prev_stall <= bus_if.out_valid && !bus_if.out_ready;
      prev_data  <= bus_if.out_data;
      if (bus_if.out_valid && bus_if.out_ready) rxq.push_back(bus_if.out_data);
      if (prev_done) busy_after_done <= busy;
      if (done) busy_at_done <= busy;
      prev_done <= done;
    end
  end

  int         total = 0;
  int         bad   = 0;
  logic       kill  = 1'b0;
  logic [7:0] txq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rx(input int n, input logic [63:0] exp);
    check("rx_count", rxq.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < rxq.size()) check($sformatf("rx_byte%0d", k), rxq[k], exp[63-8*k -: 8]);
    end
  endtask

  task automatic set_job(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] w3, input int vlen, input logic [7:0] x0,
                         input logic [7:0] step);
    txq.delete();
    txq.push_back(w0); txq.push_back(w1); txq.push_back(w2); txq.push_back(w3);
    for (int i = 0; i < vlen; i++) txq.push_back(x0 + 8'(i) * step);
    exp_x = vlen;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic start_job(input logic [7:0] vlen);
    @(posedge clk); #1;
    start = 1'b1; vec_len = vlen;
    @(posedge clk); #1;
    start = 1'b0; vec_len = 8'd0;
  endtask

  task automatic host_send(input bit gaps);
    int   i      = 0;
    int   budget = 5000;
    bit   tog    = 1'b0;
    logic hs;
    while (i < txq.size() && !kill && budget > 0) begin
      bus_if.in_valid = gaps ? tog : 1'b1;
      bus_if.in_data  = txq[i];
      @(negedge clk);
      hs = bus_if.in_valid && bus_if.in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      tog = !tog;
      budget--;
    end
    if (budget == 0) check("host_budget", i, txq.size());
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'd0;
  endtask

  task automatic consume(input int nbytes, input int stall);
    int got    = 0;
    int budget = 2000;
    if (stall == 0) begin
      bus_if.out_ready = 1'b1;
      while (rxq.size() < nbytes && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      @(posedge clk); #1;
      bus_if.out_ready = 1'b0;
    end else begin
      while (got < nbytes && budget > 0) begin
        @(negedge clk);
        budget--;
        if (bus_if.out_valid) begin
          repeat (stall) begin @(posedge clk); #1; end
          bus_if.out_ready = 1'b1;
          @(posedge clk); #1;
          bus_if.out_ready = 1'b0;
          got++;
        end
      end
    end
  endtask

  task automatic wait_done();
    int budget = 100;
    while (n_done == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic poke_start();
    int budget = 200;
    while (!bus_if.pe_x_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("poke_found_stream", budget > 0, 1);
    @(posedge clk); #1;
    start = 1'b1; vec_len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'd0;
    bus_if.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", bus_if.in_ready, 0);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_out_data", bus_if.out_data, 0);
    check("rst_pe_strobes", {bus_if.pe_w_load, bus_if.pe_acc_clr, bus_if.pe_x_valid,
                             bus_if.pe_out_shift}, 0);

    // Basic job, continuous valid/ready: results 44,33,22,11.
    set_job(8'd1, 8'd2, 8'd3, 8'd4, 2, 8'd5, 8'd1);
    mon_reset();
    start_job(8'd2);
    fork
      host_send(1'b0);
      consume(8, 0);
    join
    wait_done();
    check_rx(8, 64'h2C00_2100_1600_0B00);
    check("t1_w_load", n_wl, 4);
    check("t1_acc_clr", n_clr, 1);
    check("t1_x_valid", n_xv, 2);
    check("t1_bubbles", n_bub, 0);
    check("t1_shift", n_sh, 3);
    check("t1_done", n_done, 1);
    check("t1_busy_at_done", busy_at_done, 1);
    check("t1_busy_after_done", busy_after_done, 0);
    check("t1_err", n_err, 0);

    // Host gaps, consumer stalls, stray start during STREAM.
    mon_reset();
    start_job(8'd2);
    fork
      host_send(1'b1);
      consume(8, 3);
      poke_start();
    join
    wait_done();
    check_rx(8, 64'h2C00_2100_1600_0B00);
    check("t2_stall_stable", n_stall_bad, 0);
    check("t2_bubbles_seen", n_bub > 0, 1);
    check("t2_w_load", n_wl, 4);
    check("t2_x_valid", n_xv, 2);
    check("t2_shift", n_sh, 3);
    check("t2_done", n_done, 1);
    check("t2_err", n_err, 0);

    // Zero-length start is rejected.
    mon_reset();
    @(posedge clk); #1;
    start = 1'b1; vec_len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_err", n_err, 1);
    check("t3_busy", n_busy, 0);
    check("t3_pe_activity", n_wl + n_clr + n_xv + n_sh, 0);

    // Abort with start in the same cycle: abort wins.
    mon_reset();
    @(posedge clk); #1;
    start = 1'b1; vec_len = 8'd3; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; vec_len = 8'd0; abort = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_abort_start_busy", n_busy, 0);
    check("t3_abort_start_err", n_err, 0);

    // Abort mid-READ after three bytes.
    set_job(8'd1, 8'd2, 8'd3, 8'd4, 2, 8'd5, 8'd1);
    mon_reset();
    start_job(8'd2);
    fork
      host_send(1'b0);
      consume(3, 1);
    join
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("t4_out_valid", bus_if.out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_in_ready", bus_if.in_ready, 0);
    repeat (10) @(negedge clk);
    check("t4_done", n_done, 0);
    check_rx(3, 64'h2C00_2100_0000_0000);

    // Follow-up job: weights 2,0,1,3, x=10,20,30 -> tail-first 180,60,0,120.
    set_job(8'd2, 8'd0, 8'd1, 8'd3, 3, 8'd10, 8'd10);
    mon_reset();
    start_job(8'd3);
    fork
      host_send(1'b0);
      consume(8, 0);
    join
    wait_done();
    check_rx(8, 64'hB400_3C00_0000_7800);
    check("t4b_done", n_done, 1);

    // Asynchronous reset mid-STREAM.
    set_job(8'd1, 8'd2, 8'd3, 8'd4, 10, 8'd1, 8'd1);
    mon_reset();
    start_job(8'd10);
    fork
      host_send(1'b0);
      begin
        poke_wait_x();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_in_ready", bus_if.in_ready, 0);
        check("t5_x_valid", bus_if.pe_x_valid, 0);
        check("t5_x_data", bus_if.pe_x_data, 0);
        check("t5_out_valid", bus_if.out_valid, 0);
        kill = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    join
    kill = 1'b0;

    // Longest job: vec_len 255, all ones -> 255 per PE.
    set_job(8'd1, 8'd1, 8'd1, 8'd1, 255, 8'd1, 8'd0);
    mon_reset();
    start_job(8'd255);
    fork
      host_send(1'b0);
      consume(8, 0);
    join
    wait_done();
    check_rx(8, 64'hFF00_FF00_FF00_FF00);
    check("t5_x_count", n_xv, 255);
    check("t5_done", n_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic poke_wait_x();
    int budget = 200;
    while (n_xv < 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("t5_reached_stream", budget > 0, 1);
  endtask

endmodule

// File: doc/systolic_chain_sequencer.md
Name: systolic_chain_sequencer

Overview:
Sequences one job through an N_PE-deep weight-stationary MAC chain (systolic PE chain). Accepts a byte stream from the host: N_PE weights, then vec_len activations. Loads the weights, clears the accumulators, streams the activations and waits for the pipeline to drain. Returns each PE accumulator as ACC_W/8 bytes, LSB first, over a valid/ready output.

Parameters:
N_PE, 4, number of PEs in chain (2..16)
DATA_W, 8, weight/activation width (fixed to 8, matches byte stream)
ACC_W, 16, PE accumulator width; must be a multiple of 8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse; honoured only in IDLE
vec_len  in  8  activation count, latched on accepted start
abort  in  1  synchronous abort, any state
in_data  in  8  host byte (weight or activation)
in_valid  in  1  host byte valid
in_ready  out  1  sequencer accepts byte
pe_w_load  out  1  shift pe_w_data into chain weight registers
pe_w_data  out  8  weight to chain
pe_acc_clr  out  1  clear all PE accumulators
pe_x_valid  out  1  activation valid into chain head
pe_x_data  out  8  activation to chain head
pe_out_shift  out  1  shift accumulators one PE toward tail
pe_res  in  ACC_W  tail PE accumulator
out_data  out  8  result byte
out_valid  out  1  result byte valid
out_ready  in  1  consumer ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle job-complete pulse
err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset: state IDLE. All outputs 0, counters 0. Reset is asynchronous.
- All pe_* outputs are registered. A pe_* strobe appears the cycle after the enabling handshake or state and lasts exactly 1 cycle per event.
- IDLE: in_ready=0. If start=1 and vec_len!=0, latch vec_len and go to LOAD_W. If start=1 and vec_len==0, pulse err=1 next cycle and stay in IDLE. A start seen in any other state is ignored, with no err.
- LOAD_W: in_ready=1. Each in_valid&in_ready handshake gives pe_w_load=1 and pe_w_data=in_data the next cycle. After N_PE handshakes, go to ACC_CLR. Handshakes may have gaps.
- ACC_CLR: lasts 1 cycle. in_ready=0 and pe_acc_clr=1 in the following cycle. Then go to STREAM.
- STREAM: in_ready=1. Each handshake gives pe_x_valid=1 and pe_x_data=in_data the next cycle. Host bubbles produce pe_x_valid=0. After vec_len handshakes, in_ready drops in the same cycle as the last accept and the state goes to DRAIN.
- DRAIN: in_ready=0 for exactly N_PE+1 cycles (chain latency plus register stage), then go to READ.
- READ: handles results r=0..N_PE-1, taking pe_res at the time it is presented.
  - out_valid=1 with byte b=0..ACC_W/8-1 of pe_res, LSB first.
  - Each byte advances only on out_valid&out_ready. out_data and out_valid are held stable while out_ready=0.
  - After the last byte of a result is accepted: out_valid=0 for 1 cycle and pe_out_shift=1 that cycle. The next result is presented the cycle after.
  - After the last byte of result N_PE-1: no pe_out_shift is issued; go to DONE.
- DONE: done=1 for 1 cycle, busy=1, then go to IDLE.
- abort=1 in any state: next cycle state=IDLE and all outputs return to reset values. Any half-sent result is discarded. Abort has priority over start in the same cycle. Abort in IDLE has no effect.
- Counters: weight counter is log2(N_PE)+1 bits, activation counter is 8 bits compared against latched vec_len, byte counter is log2(ACC_W/8). No wrap-around is possible; vec_len=255 must complete.
- Reset asserted mid-job: immediate return to IDLE with all outputs 0. No state persists.
- Result order: tail PE (index N_PE-1) first, head PE last.

Test Plan:
- N_PE=4, ACC_W=16, behavioural chain model. Weights 1,2,3,4 and x=5,6 (vec_len=2), continuous valid and ready -> 4 pe_w_load strobes, 1 pe_acc_clr, 2 pe_x_valid. Out bytes 2C,00,21,00,16,00,0B,00 (results 44,33,22,11). 3 pe_out_shift strobes, done pulses once, busy falls the cycle after done.
- Same job with in_valid toggling 1/0 and out_ready held low 3 cycles per byte -> identical byte sequence. out_data stays stable during stalls. pe_x_valid shows bubbles. No byte duplicated or lost.
- start with vec_len=0 -> err pulses 1 cycle, busy stays 0, no pe_* activity. A start asserted during STREAM is ignored and err stays 0.
- abort asserted mid-READ after byte 3 -> next cycle IDLE, out_valid=0, busy=0, no done. A following normal job produces correct results.
- rst_n pulsed low asynchronously mid-STREAM -> all outputs 0 immediately, state IDLE. The next job with vec_len=255, weights all 1 and x all 1 returns 255 (FF,00) for each PE.
